systolic_collect_out: RTL



---
 rtl/systolic_collect_pkg.sv | 21 ++
 rtl/systolic_collect_lane.sv | 50 +++++
 rtl/systolic_collect_out.sv | 88 ++++++++
 3 files changed

// File: rtl/systolic_collect_pkg.sv
// Shared constants and element addressing for the systolic array edge logic.
// The left-side feeder and the bottom-side collector use the same element layout.
package systolic_collect_pkg;

  localparam int DATA_SIZE   = 8;
  localparam int MAC_WIDTH   = 4;
  localparam int RESULT_SIZE = 2 * DATA_SIZE;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } collect_state_e;

  // Bit offset of element (r,c) inside a flattened row-major matrix.
  function automatic int elem_offset(input int r, input int c,
                                     input int mac_width   = MAC_WIDTH,
                                     input int result_size = RESULT_SIZE);
    return (r * mac_width + c) * result_size;
  endfunction

endpackage

// File: rtl/systolic_collect_lane.sv
// One output column of the array: tracks which row the next beat lands in,
// whether the column is complete, and flags beats that arrive after completion.
module systolic_collect_lane
  import systolic_collect_pkg::*;
#(
  parameter int MAC_WIDTH = systolic_collect_pkg::MAC_WIDTH,
  parameter int ROW_W     = (MAC_WIDTH > 1) ? $clog2(MAC_WIDTH) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             beat_valid,
  input  logic             in_ready,
  input  logic             clear,
  output logic             wr_en,
  output logic [ROW_W-1:0] wr_row,
  output logic             done,
  output logic             overflow
);

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(MAC_WIDTH - 1);

  logic [ROW_W-1:0] row_cnt;
  logic             done_q;
  logic             last_beat;

  always_comb begin
    wr_en     = beat_valid && in_ready && !done_q;
    overflow  = beat_valid && in_ready && done_q;
    wr_row    = row_cnt;
    last_beat = wr_en && (row_cnt == LAST_ROW);
    // Includes a completing beat accepted this cycle so the top can leave
    // COLLECT on the same edge that writes the final element.
    done      = done_q || last_beat;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      row_cnt <= '0;
      done_q  <= 1'b0;
    end else begin
      if (clear)          done_q <= 1'b0;
      else if (last_beat) done_q <= 1'b1;

      if (wr_en) row_cnt <= (row_cnt == LAST_ROW) ? '0 : row_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/systolic_collect_out.sv
// De-skews per-column result streams from the array's bottom edge into one
// result matrix and offers it on a valid/ready handshake with a single buffer.
module systolic_collect_out
  import systolic_collect_pkg::*;
#(
  parameter int MAC_WIDTH   = systolic_collect_pkg::MAC_WIDTH,
  parameter int RESULT_SIZE = systolic_collect_pkg::RESULT_SIZE
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic [RESULT_SIZE*MAC_WIDTH-1:0]       lane_in,
  input  logic [MAC_WIDTH-1:0]                   lane_valid,
  output logic                                   in_ready,
  output logic [RESULT_SIZE*MAC_WIDTH*MAC_WIDTH-1:0] matrix_out,
  output logic                                   matrix_valid,
  input  logic                                   matrix_ready,
  output logic                                   overflow_err
);

  localparam int ROW_W = (MAC_WIDTH > 1) ? $clog2(MAC_WIDTH) : 1;

  collect_state_e state_q, state_d;

  logic [MAC_WIDTH-1:0] wr_en;
  logic [MAC_WIDTH-1:0] lane_done;
  logic [MAC_WIDTH-1:0] lane_overflow;
  logic [ROW_W-1:0]     wr_row [MAC_WIDTH];
  logic                 handoff;

  assign in_ready     = (state_q == COLLECT);
  assign matrix_valid = (state_q == HOLD);
  assign handoff      = matrix_valid && matrix_ready;

  for (genvar g = 0; g < MAC_WIDTH; g++) begin : g_lane
    systolic_collect_lane #(
      .MAC_WIDTH (MAC_WIDTH),
      .ROW_W     (ROW_W)
    ) u_lane (
      .clock      (clock),
      .reset      (reset),
      .beat_valid (lane_valid[g]),
      .in_ready   (in_ready),
      .clear      (handoff),
      .wr_en      (wr_en[g]),
      .wr_row     (wr_row[g]),
      .done       (lane_done[g]),
      .overflow   (lane_overflow[g])
    );
  end

  // NOTE: the default assignment first keeps every path assigned, so no latch
  // is inferred for state_d.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      COLLECT: if (&lane_done)   state_d = HOLD;
      HOLD:    if (matrix_ready) state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= COLLECT;
    else       state_q <= state_d;
  end

  // NOTE: the matrix buffer is reset because its value is a visible output;
  // between matrices it is simply overwritten, never cleared.
  always_ff @(posedge clock) begin
    if (reset) begin
      matrix_out <= '0;
    end else begin
      for (int r = 0; r < MAC_WIDTH; r++) begin
        for (int c = 0; c < MAC_WIDTH; c++) begin
          if (wr_en[c] && (wr_row[c] == ROW_W'(r)))
            matrix_out[elem_offset(r, c, MAC_WIDTH, RESULT_SIZE) +: RESULT_SIZE]
              <= lane_in[c*RESULT_SIZE +: RESULT_SIZE];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset)               overflow_err <= 1'b0;
    else if (|lane_overflow) overflow_err <= 1'b1;
  end

endmodule
